// File: rtl/led_pkg.sv
// led_pkg: shared LED channel mode type and constants
package led_pkg;
  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_ONESHOT = 2'd3
  } led_mode_t;
endpackage

// File: rtl/led_channel.sv
// led_channel: state for one LED channel (mode, period, counter, led, busy)
module led_channel
  import led_pkg::*;
#(
  parameter int CTR_W = 24,
  parameter int unsigned DEFAULT_PERIOD = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  led_mode_t        mode_in,
  input  logic [CTR_W-1:0] period_in,
  input  logic             sync,
  output logic             led,
  output logic             busy
);
  led_mode_t        mode;
  logic [CTR_W-1:0] period;
  logic [CTR_W-1:0] ctr;
  logic             tc;

  assign tc = ctr == period;

  // write beats terminal count and sync; otherwise the current mode advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   <= LED_BLINK;
      period <= CTR_W'(DEFAULT_PERIOD);
      ctr    <= '0;
      led    <= 1'b0;
      busy   <= 1'b0;
    end else if (wr) begin
      mode   <= mode_in;
      period <= period_in;
      ctr    <= '0;
      led    <= mode_in == LED_ON || mode_in == LED_ONESHOT;
      busy   <= mode_in == LED_ONESHOT;
    end else if (mode == LED_BLINK) begin
      ctr  <= sync || tc ? '0 : ctr + CTR_W'(1);
      led  <= sync ? 1'b0 : tc ? ~led : led;
      busy <= 1'b0;
    end else if (mode == LED_ONESHOT) begin
      ctr  <= tc ? '0 : ctr + CTR_W'(1);
      led  <= !tc;
      busy <= !tc;
      mode <= tc ? LED_OFF : LED_ONESHOT;
    end else begin
      ctr  <= '0;
      led  <= mode == LED_ON;
      busy <= 1'b0;
    end
  end
endmodule

// File: rtl/led_blinker_multi.sv
// led_blinker_multi: multi-channel LED driver with config write decode and range error flag
module led_blinker_multi
  import led_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CTR_W = 24,
  parameter int unsigned DEFAULT_PERIOD = 500000,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CTR_W-1:0]    cfg_period,
  input  logic                sync,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] led
);
  logic bad_ch;

  assign bad_ch = int'(cfg_ch) >= CHANNELS;

  // flag a write aimed past the last channel for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else cfg_err <= cfg_we && bad_ch;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;
    assign wr = cfg_we && int'(cfg_ch) == i;
    led_channel #(.CTR_W(CTR_W), .DEFAULT_PERIOD(DEFAULT_PERIOD)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr),
      .mode_in  (led_mode_t'(cfg_mode)),
      .period_in(cfg_period),
      .sync     (sync),
      .led      (led[i]),
      .busy     (busy[i])
    );
  end
endmodule

// File: tb/tb_led_blinker_multi.sv
// tb_led_blinker_multi: directed checks of blink, oneshot, on/off, sync, range error and async reset
module tb_led_blinker_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_period = '0;
  logic       sync = 1'b0;
  logic       cfg_err;
  logic [3:0] busy, led;
  logic       e_we = 1'b0;
  logic [1:0] e_ch = '0;
  logic [1:0] e_mode = '0;
  logic [7:0] e_period = '0;
  logic       e_err;
  logic [2:0] e_busy, e_led;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_blinker_multi #(.CHANNELS(4), .CTR_W(8), .DEFAULT_PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .sync(sync), .cfg_err(cfg_err), .busy(busy), .led(led)
  );

  led_blinker_multi #(.CHANNELS(3), .CTR_W(8), .DEFAULT_PERIOD(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(e_we), .cfg_ch(e_ch), .cfg_mode(e_mode),
    .cfg_period(e_period), .sync(1'b0), .cfg_err(e_err), .busy(e_busy), .led(e_led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] per);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_period = per;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_err", 32'(cfg_err), 32'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk($sformatf("blink_default_e%0d", e), 32'(led), ((e / 5) % 2) ? 32'hF : 32'h0);
      chk("blink_busy", 32'(busy), 32'h0);
    end
    chk("no_err", 32'(cfg_err), 32'h0);
    do_reset();
    repeat (10) tick();
    wr(2'd1, 2'd2, 8'd0);
    chk("p0_e11", 32'(led), 32'h0);
    tick(); chk("p0_e12", 32'(led), 32'h2);
    tick(); chk("p0_e13", 32'(led), 32'h0);
    tick(); chk("p0_e14", 32'(led), 32'h2);
    tick(); chk("p0_e15", 32'(led), 32'hD);
    tick(); chk("p0_e16", 32'(led), 32'hF);
    do_reset();
    wr(2'd2, 2'd3, 8'd9);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("oneshot_led_c%0d", k), 32'(led[2]), 32'h1);
      chk($sformatf("oneshot_busy_c%0d", k), 32'(busy), 32'h4);
      tick();
    end
    chk("oneshot_end_led", 32'(led[2]), 32'h0);
    chk("oneshot_end_busy", 32'(busy), 32'h0);
    repeat (6) tick();
    chk("oneshot_off_led", 32'(led[2]), 32'h0);
    chk("oneshot_off_busy", 32'(busy[2]), 32'h0);
    wr(2'd2, 2'd3, 8'd9);
    repeat (4) tick();
    wr(2'd2, 2'd3, 8'd9);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("rewrite_busy_c%0d", k), 32'(busy[2]), 32'h1);
      tick();
    end
    chk("rewrite_end_led", 32'(led[2]), 32'h0);
    chk("rewrite_end_busy", 32'(busy[2]), 32'h0);
    wr(2'd0, 2'd1, 8'd3);
    wr(2'd3, 2'd0, 8'd3);
    for (int k = 0; k < 50; k++) begin
      chk("on_ch0", 32'(led[0]), 32'h1);
      chk("off_ch3", 32'(led[3]), 32'h0);
      tick();
    end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_on_ch0", 32'(led[0]), 32'h1);
    chk("sync_off_ch3", 32'(led[3]), 32'h0);
    tick();
    chk("sync_on_ch0_b", 32'(led[0]), 32'h1);
    do_reset();
    tick();
    e_we = 1'b1; e_ch = 2'd3; e_mode = 2'd1; e_period = 8'd0;
    tick();
    e_we = 1'b0;
    chk("range_err_pulse", 32'(e_err), 32'h1);
    chk("range_led_same", 32'(e_led), 32'h0);
    tick();
    chk("range_err_clear", 32'(e_err), 32'h0);
    repeat (2) tick();
    chk("range_phase_kept", 32'(e_led), 32'h7);
    e_we = 1'b1; e_ch = 2'd2; e_mode = 2'd1;
    tick();
    e_we = 1'b0;
    chk("valid_no_err", 32'(e_err), 32'h0);
    chk("valid_on_led", 32'(e_led), 32'h7);
    do_reset();
    repeat (2) tick();
    sync = 1'b1;
    wr(2'd1, 2'd2, 8'd2);
    sync = 1'b0;
    chk("sync_wr_e3", 32'(led), 32'h0);
    for (int e = 4; e <= 12; e++) begin
      logic o, c;
      tick();
      o = e >= 8;
      c = (e >= 6 && e < 9) || e >= 12;
      chk($sformatf("sync_wr_e%0d", e), 32'(led), 32'({o, o, c, o}));
    end
    wr(2'd2, 2'd3, 8'd9);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
